// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost mode scheduler.
// Mode/state enums, timer width, capture scoring constants.
package ghost_pkg;

  typedef enum logic [1:0] {
    SCATTER    = 2'd0,
    CHASE      = 2'd1,
    FRIGHTENED = 2'd2
  } ghost_mode_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCHED  = 2'd1,
    S_FRIGHT = 2'd2
  } sched_state_t;

  localparam int          TW          = 12;
  localparam logic [10:0] BASE_POINTS = 11'd200;
  localparam logic [2:0]  LAST_PHASE  = 3'd7;

  function automatic ghost_mode_t phase_mode(
    input logic [2:0] p
  );
    return p[0] ? CHASE : SCATTER;
  endfunction

endpackage

// File: rtl/ghost_mode_scheduler_if.sv
// Game-side bundle of the ghost mode scheduler.
// master: game/testbench side; slave: scheduler side.
interface ghost_mode_scheduler_if;
  logic        frameTick;
  logic        initGame;
  logic        playGame;
  logic [3:0]  level;
  logic        powerPellet;
  logic        ghostEaten;
  logic [1:0]  ghostMode;
  logic        modeChange;
  logic        frightFlash;
  logic        pointsValid;
  logic [10:0] ghostPoints;

  modport master (
    output frameTick, initGame, playGame,
    output level, powerPellet, ghostEaten,
    input  ghostMode, modeChange, frightFlash,
    input  pointsValid, ghostPoints
  );

  modport slave (
    input  frameTick, initGame, playGame,
    input  level, powerPellet, ghostEaten,
    output ghostMode, modeChange, frightFlash,
    output pointsValid, ghostPoints
  );
endinterface

// File: rtl/ghost_mode_scheduler_timer.sv
// mode_timer: loadable down-counter; load beats tick.
// Ports: clk, reset, i_load, i_val, i_tick, o_count, o_zero.
module mode_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_tick,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_val;
    end else if (i_tick && r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Ghost global mode sequencer: scatter/chase schedule,
// frightened override, capture scoring.
// Ports: clk, reset (async, active high), bus (slave):
//   in : frameTick initGame playGame level powerPellet
//        ghostEaten
//   out: ghostMode modeChange frightFlash pointsValid
//        ghostPoints (all registered)
module ghost_mode_scheduler
  import ghost_pkg::*;
#(
  parameter int SCATTER_FRAMES = 420,
  parameter int CHASE_FRAMES   = 1200,
  parameter int FRIGHT_FRAMES  = 360,
  parameter int FRIGHT_STEP    = 30,
  parameter int FLASH_FRAMES   = 120
) (
  input  logic                   clk,
  input  logic                   reset,
  ghost_mode_scheduler_if.slave  bus
);

  sched_state_t r_state, nx_state;
  logic [2:0]   r_phase, nx_phase;
  logic [1:0]   r_eat, nx_eat;
  ghost_mode_t  r_mode, nx_mode;
  logic         r_flash, nx_flash;
  logic         r_mc, nx_mc;
  logic         r_pv, nx_pv;
  logic [10:0]  r_pts, nx_pts;

  logic          w_run;
  logic [TW-1:0] w_fstep, w_flen;
  logic [2:0]    w_phase_nxt;
  logic          w_s_load, w_f_load;
  logic [TW-1:0] w_s_val, w_f_val;
  logic          w_s_tick, w_f_tick;
  logic [TW-1:0] w_s_cnt, w_f_cnt;
  logic          w_s_zero, w_f_zero;
  logic          w_s_exp, w_f_exp;

  function automatic logic [TW-1:0] sched_len(
    input logic [2:0] p,
    input logic [3:0] lv
  );
    if (p == LAST_PHASE) return '0;
    if (p[0]) return TW'(CHASE_FRAMES);
    return (lv < 4'd2) ? TW'(SCATTER_FRAMES)
                       : TW'(SCATTER_FRAMES / 2);
  endfunction

  assign w_run   = bus.playGame && !bus.initGame;
  assign w_fstep = TW'(bus.level) * TW'(FRIGHT_STEP);
  assign w_flen  = (w_fstep >= TW'(FRIGHT_FRAMES)) ? '0
                 : TW'(FRIGHT_FRAMES) - w_fstep;

  assign w_phase_nxt = (r_phase == LAST_PHASE) ? r_phase
                     : r_phase + 3'd1;

  // A zero count means "no timer" (phase 7) in SCHED.
  assign w_s_tick = w_run && bus.frameTick && !w_s_zero
                 && (r_state == S_SCHED);
  // A pellet in FRIGHT takes the cycle; its tick is dropped.
  assign w_f_tick = w_run && bus.frameTick && !w_f_zero
                 && (r_state == S_FRIGHT) && !bus.powerPellet;

  assign w_s_exp = w_s_tick && (w_s_cnt == TW'(1));
  assign w_f_exp = w_f_tick && (w_f_cnt == TW'(1));

  mode_timer #(.W(TW)) u_sched_tmr (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_s_load),
    .i_val   (w_s_val),
    .i_tick  (w_s_tick),
    .o_count (w_s_cnt),
    .o_zero  (w_s_zero)
  );

  mode_timer #(.W(TW)) u_fright_tmr (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_f_load),
    .i_val   (w_f_val),
    .i_tick  (w_f_tick),
    .o_count (w_f_cnt),
    .o_zero  (w_f_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_eat   <= '0;
      r_mode  <= SCATTER;
      r_flash <= 1'b0;
      r_mc    <= 1'b0;
      r_pv    <= 1'b0;
      r_pts   <= '0;
    end else begin
      r_state <= nx_state;
      r_phase <= nx_phase;
      r_eat   <= nx_eat;
      r_mode  <= nx_mode;
      r_flash <= nx_flash;
      r_mc    <= nx_mc;
      r_pv    <= nx_pv;
      r_pts   <= nx_pts;
    end
  end

  always_comb begin
    nx_state = r_state;
    nx_phase = r_phase;
    nx_eat   = r_eat;
    nx_mode  = r_mode;
    nx_flash = r_flash;
    nx_mc    = 1'b0;
    nx_pv    = 1'b0;
    nx_pts   = r_pts;
    w_s_load = 1'b0;
    w_s_val  = '0;
    w_f_load = 1'b0;
    w_f_val  = '0;
    if (bus.initGame) begin
      nx_state = S_IDLE;
      nx_phase = '0;
      nx_eat   = '0;
      nx_mode  = SCATTER;
      nx_flash = 1'b0;
      w_s_load = 1'b1;
      w_f_load = 1'b1;
    end else if (bus.playGame) begin
      unique case (r_state)
        S_IDLE: begin
          nx_state = S_SCHED;
          w_s_load = 1'b1;
          w_s_val  = sched_len(r_phase, bus.level);
        end
        S_SCHED: begin
          if (w_s_exp) begin
            nx_phase = w_phase_nxt;
            nx_mode  = phase_mode(w_phase_nxt);
            nx_mc    = 1'b1;
            w_s_load = 1'b1;
            w_s_val  = sched_len(w_phase_nxt, bus.level);
          end
          // Expiry and pellet together still give one pulse.
          if (bus.powerPellet) begin
            nx_mc = 1'b1;
            if (w_flen != '0) begin
              nx_state = S_FRIGHT;
              nx_mode  = FRIGHTENED;
              nx_eat   = '0;
              nx_flash = (w_flen <= TW'(FLASH_FRAMES));
              w_f_load = 1'b1;
              w_f_val  = w_flen;
            end
          end
        end
        S_FRIGHT: begin
          if (bus.powerPellet) begin
            if (w_flen != '0) begin
              nx_eat   = '0;
              nx_flash = (w_flen <= TW'(FLASH_FRAMES));
              w_f_load = 1'b1;
              w_f_val  = w_flen;
            end
          end else begin
            if (bus.ghostEaten) begin
              nx_pts = BASE_POINTS << r_eat;
              nx_pv  = 1'b1;
              if (r_eat != 2'd3) nx_eat = r_eat + 2'd1;
            end
            if (w_f_exp) begin
              nx_state = S_SCHED;
              nx_mode  = phase_mode(r_phase);
              nx_flash = 1'b0;
            end else if (w_f_tick) begin
              nx_flash = (w_f_cnt - TW'(1))
                      <= TW'(FLASH_FRAMES);
            end
          end
        end
        default: nx_state = S_IDLE;
      endcase
    end
  end

  assign bus.ghostMode   = r_mode;
  assign bus.modeChange  = r_mc;
  assign bus.frightFlash = r_flash;
  assign bus.pointsValid = r_pv;
  assign bus.ghostPoints = r_pts;

endmodule
